hazard_nop_ctrl: RTL and testbench
==================================

Name: hazard_nop_ctrl

Overview:
- Parametrised successor to the pipeline control unit's fixed two-NOP JAL insertion logic.
- Sits beside the decode-stage control decoder. Centrally generates pipeline flush (NOP insertion), stall and bubble controls for:
  - JAL detected in ID,
  - branch/JALR redirects resolved in EX,
  - load-use hazards.
- Each event's penalty depth is set per parameter.
- Also provides saturating performance counters for flush and stall cycles.

Parameters:
- JAL_FLUSH, 2, consecutive flush cycles for a JAL detected in ID (1..7).
- BR_FLUSH, 2, consecutive flush cycles for an EX redirect (1..7).
- LU_STALL, 1, consecutive stall cycles for a load-use hazard (1..7).
- REG_AW, 5, register index width.
- PERF_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- opcode_id_i  in  7  opcode of the instruction in ID.
- rs1_id_i  in  REG_AW  rs1 index in ID.
- rs2_id_i  in  REG_AW  rs2 index in ID.
- rs_used_i  in  2  [0]=ID uses rs1, [1]=ID uses rs2.
- ex_is_load_i  in  1  instruction in EX is a load.
- rd_ex_i  in  REG_AW  destination of the instruction in EX.
- ex_redirect_i  in  1  taken branch or JALR resolved in EX this cycle.
- flush_o  out  1  replace IF/ID and ID/EX contents with NOP.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  insert NOP into ID/EX only.
- busy_o  out  1  FSM not in S_RUN.
- flush_cycles_o  out  PERF_W  count of cycles with flush_o=1.
- stall_cycles_o  out  PERF_W  count of cycles with stall_o=1.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - While rst=1: all outputs are forced to 0 combinationally. On the next edge: state=S_RUN, cnt=0, both perf counters=0.
  - Reset asserted mid-flush or mid-stall aborts the operation with no residual flush/stall cycle.
- Event detection (combinational):
  - jal_det = (opcode_id_i==J opcode 7'b1101111).
  - lu_det = ex_is_load_i && rd_ex_i!=0 && ((rs_used_i[0] && rs1_id_i==rd_ex_i) || (rs_used_i[1] && rs2_id_i==rd_ex_i)).
- Internal state: FSM states S_RUN, S_FLUSH, S_STALL; down-counter cnt, 3 bits.
- Outputs are Mealy. Each event asserts its output in the detection cycle, with zero latency, and for exactly N consecutive cycles total.
- Priority in any state: ex_redirect_i > jal_det > lu_det.
- S_RUN:
  - ex_redirect_i: flush_o=1; cnt<=BR_FLUSH-1; go S_FLUSH if BR_FLUSH>1, else stay.
  - else jal_det: flush_o=1; cnt<=JAL_FLUSH-1; same transition rule.
  - else lu_det: stall_o=1, bubble_o=1; cnt<=LU_STALL-1; go S_STALL if LU_STALL>1.
  - else all 0.
- S_FLUSH:
  - flush_o=1, busy_o=1.
  - ex_redirect_i restarts: cnt<=BR_FLUSH-1, and this cycle counts as flush cycle 1.
  - jal_det and lu_det are ignored (those instructions are being flushed).
  - Otherwise cnt<=cnt-1; go S_RUN when cnt==1.
- S_STALL:
  - stall_o=1, bubble_o=1, busy_o=1.
  - ex_redirect_i aborts the stall: stall_o=0, bubble_o=0, flush_o=1; enter flush sequence as from S_RUN.
  - Otherwise cnt<=cnt-1; go S_RUN when cnt==1.
  - lu_det is not re-evaluated in S_STALL. On return to S_RUN, a still-true lu_det starts a new stall.
- Exclusivity: flush_o and stall_o are never 1 in the same cycle. bubble_o=1 only while stall_o=1.
- Perf counters:
  - Increment on each edge where the respective output is 1.
  - Saturate at all-ones; no wrap.
- Out-of-range parameters (0 or >7) fail an elaboration-time check.

Test Plan:
- Defaults, single JAL in ID for 1 cycle, then ADDs -> flush_o=1 for exactly 2 cycles starting in the JAL cycle; busy_o=1 in cycle 2 only; flush_cycles_o=2.
- JAL_FLUSH=3, BR_FLUSH=1; ex_redirect_i pulse, then 4 idle cycles later a JAL -> flush_o for 1 cycle, then for 3 cycles; flush_cycles_o=4.
- Defaults: load with rd=x5 in EX, ID uses rs2=x5 -> stall_o=bubble_o=1 for 1 cycle, flush_o=0. Same stimulus with rd=x0 -> no stall.
- LU_STALL=3: load-use hazard, ex_redirect_i in stall cycle 2 -> stall_o drops that cycle, flush_o=1 for 2 cycles; stall_cycles_o=1.
- BR_FLUSH=4: redirect at t0, second redirect at t2 -> flush_o high t0..t5 (6 cycles). rst=1 at t3 -> flush_o=0 at t3; counters 0 after the t3 edge.
- PERF_W=4: 20 back-to-back JALs -> flush_cycles_o saturates at 15 and holds.

Source files
------------

// File: rtl/hazard_nop_ctrl.sv
// Pipeline hazard control: flush/stall/bubble generation for JAL in ID, EX redirects and load-use.
// Zero-latency Mealy outputs held for a per-event cycle count; no backpressure, pipeline obeys outputs.
module hazard_nop_ctrl #(
    parameter int JAL_FLUSH = 2,
    parameter int BR_FLUSH  = 2,
    parameter int LU_STALL  = 1,
    parameter int REG_AW    = 5,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode_id_i,
    input  logic [REG_AW-1:0] rs1_id_i,
    input  logic [REG_AW-1:0] rs2_id_i,
    input  logic [1:0]        rs_used_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] rd_ex_i,
    input  logic              ex_redirect_i,
    output logic              flush_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              busy_o,
    output logic [PERF_W-1:0] flush_cycles_o,
    output logic [PERF_W-1:0] stall_cycles_o
);

    if (JAL_FLUSH < 1 || JAL_FLUSH > 7 || BR_FLUSH < 1 || BR_FLUSH > 7 ||
        LU_STALL < 1 || LU_STALL > 7) begin : g_param_err
        $error("hazard_nop_ctrl: JAL_FLUSH, BR_FLUSH and LU_STALL must be in 1..7");
    end

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_STALL} state_t;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [2:0] JAL_CNT = 3'(JAL_FLUSH - 1);
    localparam logic [2:0] BR_CNT  = 3'(BR_FLUSH - 1);
    localparam logic [2:0] LU_CNT  = 3'(LU_STALL - 1);
    localparam state_t     JAL_NXT = (JAL_FLUSH > 1) ? S_FLUSH : S_RUN;
    localparam state_t     BR_NXT  = (BR_FLUSH > 1) ? S_FLUSH : S_RUN;
    localparam state_t     LU_NXT  = (LU_STALL > 1) ? S_STALL : S_RUN;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       jal_det, lu_det;

    assign jal_det = (opcode_id_i == OP_JAL);
    assign lu_det  = ex_is_load_i && (rd_ex_i != '0) &&
                     ((rs_used_i[0] && (rs1_id_i == rd_ex_i)) ||
                      (rs_used_i[1] && (rs2_id_i == rd_ex_i)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flush_o  = 1'b0;
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        busy_o   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_RUN: begin
                    if (ex_redirect_i) begin
                        flush_o = 1'b1;
                        cnt_d   = BR_CNT;
                        state_d = BR_NXT;
                    end else if (jal_det) begin
                        flush_o = 1'b1;
                        cnt_d   = JAL_CNT;
                        state_d = JAL_NXT;
                    end else if (lu_det) begin
                        stall_o  = 1'b1;
                        bubble_o = 1'b1;
                        cnt_d    = LU_CNT;
                        state_d  = LU_NXT;
                    end
                end
                S_FLUSH: begin
                    flush_o = 1'b1;
                    busy_o  = 1'b1;
                    // A new redirect restarts the window; this cycle is its first flush cycle.
                    if (ex_redirect_i) begin
                        cnt_d   = BR_CNT;
                        state_d = BR_NXT;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) state_d = S_RUN;
                    end
                end
                S_STALL: begin
                    busy_o = 1'b1;
                    if (ex_redirect_i) begin
                        flush_o = 1'b1;
                        cnt_d   = BR_CNT;
                        state_d = BR_NXT;
                    end else begin
                        stall_o  = 1'b1;
                        bubble_o = 1'b1;
                        cnt_d    = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating perf counters: stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cycles_o <= '0;
            stall_cycles_o <= '0;
        end else begin
            if (flush_o && (flush_cycles_o != '1)) flush_cycles_o <= flush_cycles_o + PERF_W'(1);
            if (stall_o && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_nop_ctrl.sv
// Bench for hazard_nop_ctrl: four parameterisations share one stimulus stream, checked
// against a timestamp-window reference model plus directed vectors and sequences.
module tb_hazard_nop_ctrl;

    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam int JF[4] = '{2, 3, 2, 2};
    localparam int BF[4] = '{2, 1, 2, 4};
    localparam int LS[4] = '{1, 1, 3, 1};
    localparam int PM[4] = '{65535, 65535, 65535, 15};

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] rs_used;
    logic       ex_is_load, ex_redirect;

    logic        a_fl, a_st, a_bb, a_by, b_fl, b_st, b_bb, b_by;
    logic        c_fl, c_st, c_bb, c_by, d_fl, d_st, d_bb, d_by;
    logic [15:0] a_fc, a_sc, b_fc, b_sc, c_fc, c_sc;
    logic [3:0]  d_fc, d_sc;

    int n_chk = 0;
    int n_fail = 0;
    int t = 0;
    int fe[4], se[4], fcm[4], scm[4];
    logic ef[4], es[4];
    logic last_rst = 1'b0;
    logic cnt_ok = 1'b0;

    always #5 clk = ~clk;

    hazard_nop_ctrl u_a (
        .clk(clk), .rst(rst), .opcode_id_i(opcode), .rs1_id_i(rs1), .rs2_id_i(rs2),
        .rs_used_i(rs_used), .ex_is_load_i(ex_is_load), .rd_ex_i(rd), .ex_redirect_i(ex_redirect),
        .flush_o(a_fl), .stall_o(a_st), .bubble_o(a_bb), .busy_o(a_by),
        .flush_cycles_o(a_fc), .stall_cycles_o(a_sc));

    hazard_nop_ctrl #(.JAL_FLUSH(3), .BR_FLUSH(1)) u_b (
        .clk(clk), .rst(rst), .opcode_id_i(opcode), .rs1_id_i(rs1), .rs2_id_i(rs2),
        .rs_used_i(rs_used), .ex_is_load_i(ex_is_load), .rd_ex_i(rd), .ex_redirect_i(ex_redirect),
        .flush_o(b_fl), .stall_o(b_st), .bubble_o(b_bb), .busy_o(b_by),
        .flush_cycles_o(b_fc), .stall_cycles_o(b_sc));

    hazard_nop_ctrl #(.LU_STALL(3)) u_c (
        .clk(clk), .rst(rst), .opcode_id_i(opcode), .rs1_id_i(rs1), .rs2_id_i(rs2),
        .rs_used_i(rs_used), .ex_is_load_i(ex_is_load), .rd_ex_i(rd), .ex_redirect_i(ex_redirect),
        .flush_o(c_fl), .stall_o(c_st), .bubble_o(c_bb), .busy_o(c_by),
        .flush_cycles_o(c_fc), .stall_cycles_o(c_sc));

    hazard_nop_ctrl #(.BR_FLUSH(4), .PERF_W(4)) u_d (
        .clk(clk), .rst(rst), .opcode_id_i(opcode), .rs1_id_i(rs1), .rs2_id_i(rs2),
        .rs_used_i(rs_used), .ex_is_load_i(ex_is_load), .rd_ex_i(rd), .ex_redirect_i(ex_redirect),
        .flush_o(d_fl), .stall_o(d_st), .bubble_o(d_bb), .busy_o(d_by),
        .flush_cycles_o(d_fc), .stall_cycles_o(d_sc));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, t, act, exp);
        end
    endtask

    task automatic get_out(input int i, output logic f, output logic s, output logic b,
                           output logic y, output logic [15:0] fc, output logic [15:0] sc);
        case (i)
            0: begin f = a_fl; s = a_st; b = a_bb; y = a_by; fc = a_fc; sc = a_sc; end
            1: begin f = b_fl; s = b_st; b = b_bb; y = b_by; fc = b_fc; sc = b_sc; end
            2: begin f = c_fl; s = c_st; b = c_bb; y = c_by; fc = c_fc; sc = c_sc; end
            default: begin
                f = d_fl; s = d_st; b = d_bb; y = d_by;
                fc = {12'd0, d_fc}; sc = {12'd0, d_sc};
            end
        endcase
    endtask

    // Model: each penalty is an absolute window [start, start+N-1] of cycle numbers.
    task automatic drive(input logic r, input logic [6:0] op, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [1:0] u, input logic ld,
                         input logic [4:0] d, input logic redir);
        logic f, s, busy, in_f, in_s, lu, jal;
        logic df, ds, db, dy;
        logic [15:0] dfc, dsc;
        rst = r; opcode = op; rs1 = a1; rs2 = a2; rs_used = u;
        ex_is_load = ld; rd = d; ex_redirect = redir;
        #3;
        jal = (op == OP_J);
        lu  = ld && (d != 0) && ((u[0] && a1 == d) || (u[1] && a2 == d));
        for (int i = 0; i < 4; i++) begin
            f = 1'b0; s = 1'b0; busy = 1'b0;
            if (r) begin
                fe[i] = -1; se[i] = -1;
            end else begin
                in_f = (t <= fe[i]);
                in_s = (t <= se[i]);
                busy = in_f || in_s;
                if (redir) begin
                    f = 1'b1; fe[i] = t + BF[i] - 1; se[i] = -1;
                end else if (in_f) begin
                    f = 1'b1;
                end else if (in_s) begin
                    s = 1'b1;
                end else if (jal) begin
                    f = 1'b1; fe[i] = t + JF[i] - 1;
                end else if (lu) begin
                    s = 1'b1; se[i] = t + LS[i] - 1;
                end
            end
            get_out(i, df, ds, db, dy, dfc, dsc);
            chk($sformatf("u%0d_flush", i), {31'd0, df}, {31'd0, f});
            chk($sformatf("u%0d_stall", i), {31'd0, ds}, {31'd0, s});
            chk($sformatf("u%0d_bubble", i), {31'd0, db}, {31'd0, s});
            chk($sformatf("u%0d_busy", i), {31'd0, dy}, {31'd0, busy});
            if (cnt_ok) begin
                chk($sformatf("u%0d_flush_cycles", i), {16'd0, dfc}, fcm[i]);
                chk($sformatf("u%0d_stall_cycles", i), {16'd0, dsc}, scm[i]);
            end
            ef[i] = f; es[i] = s;
        end
        last_rst = r;
    endtask

    task automatic tick();
        for (int i = 0; i < 4; i++) begin
            if (last_rst) begin
                fcm[i] = 0; scm[i] = 0;
            end else begin
                if (ef[i] && fcm[i] < PM[i]) fcm[i]++;
                if (es[i] && scm[i] < PM[i]) scm[i]++;
            end
        end
        if (last_rst) cnt_ok = 1'b1;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic rst_cycle();
        drive(1'b1, OP_ADD, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic redirect();
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic jal_in();
        drive(1'b0, OP_J, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    endtask

    typedef struct {
        logic       r;
        logic [6:0] op;
        logic [4:0] a1, a2;
        logic [1:0] u;
        logic       ld;
        logic [4:0] d;
        logic       redir;
        logic       exp_f, exp_s;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, OP_ADD, 5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, OP_ADD, 5'd0, 5'd5, 2'b01, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, OP_ADD, 5'd0, 5'd5, 2'b10, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, OP_ADD, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, OP_ADD, 5'd5, 5'd5, 2'b11, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, OP_J,   5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, OP_J,   5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, OP_ADD, 5'd30, 5'd31, 2'b11, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 7'b1101110, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, OP_J,   5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 4; i++) begin
            fe[i] = -1; se[i] = -1; fcm[i] = 0; scm[i] = 0; ef[i] = 1'b0; es[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_cycle();
        rst_cycle();

        // Single-cycle directed vectors from idle, checked on the default instance.
        for (int k = 0; k < 10; k++) begin
            rst_cycle();
            drive(vecs[k].r, vecs[k].op, vecs[k].a1, vecs[k].a2, vecs[k].u,
                  vecs[k].ld, vecs[k].d, vecs[k].redir);
            chk($sformatf("vec%0d_flush", k), {31'd0, a_fl}, {31'd0, vecs[k].exp_f});
            chk($sformatf("vec%0d_stall", k), {31'd0, a_st}, {31'd0, vecs[k].exp_s});
            chk($sformatf("vec%0d_bubble", k), {31'd0, a_bb}, {31'd0, vecs[k].exp_s});
            tick();
        end

        // Default JAL: two flush cycles, busy only in the second.
        rst_cycle();
        jal_in(); chk("jal_c0_flush", {31'd0, a_fl}, 1); chk("jal_c0_busy", {31'd0, a_by}, 0); tick();
        idle();   chk("jal_c1_flush", {31'd0, a_fl}, 1); chk("jal_c1_busy", {31'd0, a_by}, 1); tick();
        idle();   chk("jal_c2_flush", {31'd0, a_fl}, 0); chk("jal_c2_busy", {31'd0, a_by}, 0); tick();
        idle();   chk("jal_flush_cycles", {16'd0, a_fc}, 2); tick();

        // BR_FLUSH=1 redirect then JAL_FLUSH=3 JAL.
        rst_cycle();
        redirect(); chk("br1_c0_flush", {31'd0, b_fl}, 1); tick();
        for (int k = 0; k < 4; k++) begin
            idle(); chk($sformatf("br1_idle%0d_flush", k), {31'd0, b_fl}, 0); tick();
        end
        jal_in(); chk("jal3_c0_flush", {31'd0, b_fl}, 1); tick();
        for (int k = 1; k < 3; k++) begin
            idle(); chk($sformatf("jal3_c%0d_flush", k), {31'd0, b_fl}, 1); tick();
        end
        idle(); chk("jal3_end_flush", {31'd0, b_fl}, 0); chk("jal3_flush_cycles", {16'd0, b_fc}, 4); tick();

        // Load-use with rd=x5 then rd=x0.
        rst_cycle();
        drive(1'b0, OP_ADD, 5'd3, 5'd5, 2'b10, 1'b1, 5'd5, 1'b0);
        chk("lu_stall", {31'd0, a_st}, 1); chk("lu_bubble", {31'd0, a_bb}, 1); chk("lu_flush", {31'd0, a_fl}, 0);
        tick();
        idle(); chk("lu_after_stall", {31'd0, a_st}, 0); tick();
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 2'b10, 1'b1, 5'd0, 1'b0);
        chk("lu_x0_stall", {31'd0, a_st}, 0); chk("lu_x0_bubble", {31'd0, a_bb}, 0);
        tick();

        // LU_STALL=3 aborted by a redirect in stall cycle 2.
        rst_cycle();
        drive(1'b0, OP_ADD, 5'd7, 5'd0, 2'b01, 1'b1, 5'd7, 1'b0);
        chk("lu3_c0_stall", {31'd0, c_st}, 1); tick();
        redirect();
        chk("lu3_c1_stall", {31'd0, c_st}, 0); chk("lu3_c1_bubble", {31'd0, c_bb}, 0);
        chk("lu3_c1_flush", {31'd0, c_fl}, 1); chk("lu3_c1_busy", {31'd0, c_by}, 1); tick();
        idle(); chk("lu3_c2_flush", {31'd0, c_fl}, 1); tick();
        idle(); chk("lu3_c3_flush", {31'd0, c_fl}, 0); chk("lu3_stall_cycles", {16'd0, c_sc}, 1); tick();

        // BR_FLUSH=4 with a restart at t2: flush t0..t5.
        rst_cycle();
        for (int k = 0; k < 7; k++) begin
            if (k == 0 || k == 2) redirect(); else idle();
            chk($sformatf("br4_t%0d_flush", k), {31'd0, d_fl}, (k < 6) ? 1 : 0);
            tick();
        end
        idle(); chk("br4_flush_cycles", {16'd0, d_fc}, 6); tick();

        // Same, with reset at t3 cutting the window.
        rst_cycle();
        redirect(); tick();
        idle(); tick();
        redirect(); tick();
        drive(1'b1, OP_ADD, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
        chk("br4_rst_flush", {31'd0, d_fl}, 0); chk("br4_rst_busy", {31'd0, d_by}, 0); tick();
        idle();
        chk("br4_post_rst_flush", {31'd0, d_fl}, 0);
        chk("br4_post_rst_fc", {16'd0, d_fc}, 0); chk("br4_post_rst_sc", {16'd0, d_sc}, 0);
        tick();

        // PERF_W=4 saturation under 20 back-to-back JALs.
        rst_cycle();
        for (int k = 0; k < 20; k++) begin
            jal_in(); tick();
        end
        idle(); chk("sat_fc", {16'd0, d_fc}, 15); tick();
        idle(); chk("sat_fc_hold", {16'd0, d_fc}, 15); chk("sat_a_fc", {16'd0, a_fc}, 20); tick();

        // Randomised traffic on small register ranges to provoke frequent hazards.
        rst_cycle();
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 15) ? OP_J : OP_ADD,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
